// File: rtl/riffa_reg_if_batch.sv
// riffa_reg_if_batch: RIFFA command engine executing batched register commands and returning reads as one TX transaction
// Ports: clk/rst_n (sync, active-low); CHNL_RX_* command channel in; CHNL_TX_* response channel out;
// reg_q flat register bank; status_in read-only status words; err_cnt saturating bad-command count.
// Optional: define RIFFA_REG_RESET_EN to clear the register bank on reset.
module riffa_reg_if_batch_fifo #(
  parameter int W = 64,
  parameter int D = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(D):0]     count
);
  localparam int AW = $clog2(D);
  logic [W-1:0] mem [D];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr_q] <= din;
  assign dout = mem[rd_ptr_q];
  assign empty = count_q == '0;
  assign full = count_q == (AW+1)'(D);
  assign count = count_q;
endmodule

module riffa_reg_if_batch #(
  parameter int C_PCI_DATA_WIDTH = 64,
  parameter int REG_COUNT = 16,
  parameter int REG_DATA_WIDTH = 16,
  parameter int STAT_COUNT = 4,
  parameter int CMD_FIFO_DEPTH = 16,
  parameter int RSP_FIFO_DEPTH = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  output logic                                CHNL_RX_CLK,
  input  logic                                CHNL_RX,
  output logic                                CHNL_RX_ACK,
  input  logic                                CHNL_RX_LAST,
  input  logic [31:0]                         CHNL_RX_LEN,
  input  logic [30:0]                         CHNL_RX_OFF,
  input  logic [C_PCI_DATA_WIDTH-1:0]         CHNL_RX_DATA,
  input  logic                                CHNL_RX_DATA_VALID,
  output logic                                CHNL_RX_DATA_REN,
  output logic                                CHNL_TX_CLK,
  output logic                                CHNL_TX,
  input  logic                                CHNL_TX_ACK,
  output logic                                CHNL_TX_LAST,
  output logic [31:0]                         CHNL_TX_LEN,
  output logic [30:0]                         CHNL_TX_OFF,
  output logic [C_PCI_DATA_WIDTH-1:0]         CHNL_TX_DATA,
  output logic                                CHNL_TX_DATA_VALID,
  input  logic                                CHNL_TX_DATA_REN,
  output logic [REG_COUNT*REG_DATA_WIDTH-1:0] reg_q,
  input  logic [STAT_COUNT*32-1:0]            status_in,
  output logic [15:0]                         err_cnt
);
  localparam int W = C_PCI_DATA_WIDTH;
  localparam int WPB = W / 32;
  localparam int RCW = $clog2(RSP_FIFO_DEPTH) + 1;
  typedef enum logic [1:0] {RX_IDLE, RX_ACK, RX_RECV, RX_DONE} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_SEND} tx_state_e;
  rx_state_e rx_state_q, rx_state_d;
  tx_state_e tx_state_q, tx_state_d;
  logic [31:0] rx_len_q, rx_len_d, rx_cnt_q, rx_cnt_d, tx_len_q, tx_len_d;
  logic rx_last_q, rx_last_d, flush_pending_q, flush_pending_d;
  logic [RCW-1:0] tx_beats_q, tx_beats_d, tx_cnt_q, tx_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [REG_DATA_WIDTH-1:0] bank_q [REG_COUNT];
  logic [REG_DATA_WIDTH-1:0] bank_d [REG_COUNT];
  logic [W-1:0] cmd_head, rsp_head, rsp_din;
  logic cmd_empty, cmd_full, rsp_empty, rsp_full;
  logic [$clog2(CMD_FIFO_DEPTH):0] cmd_count;
  logic [RCW-1:0] rsp_count;
  logic rx_accept, exec_pop, rsp_push, tx_pop, flush_set, flush_clr, bad;
  logic [15:0] op, ea;
  logic [31:0] ed, rd_val;
  logic is_wr, is_rd, in_reg, in_any;
  logic unused_ok;
  assign CHNL_RX_CLK = clk;
  assign CHNL_TX_CLK = clk;
  assign CHNL_RX_ACK = rx_state_q == RX_ACK;
  assign CHNL_RX_DATA_REN = rx_state_q == RX_RECV && !cmd_full;
  assign rx_accept = CHNL_RX_DATA_REN && CHNL_RX_DATA_VALID;
  assign CHNL_TX = tx_state_q != TX_IDLE;
  assign CHNL_TX_LAST = 1'b1;
  assign CHNL_TX_OFF = '0;
  assign CHNL_TX_LEN = tx_len_q;
  assign CHNL_TX_DATA_VALID = tx_state_q == TX_SEND && !rsp_empty;
  assign CHNL_TX_DATA = CHNL_TX_DATA_VALID ? rsp_head : '0;
  assign tx_pop = CHNL_TX_DATA_VALID && CHNL_TX_DATA_REN;
  assign err_cnt = err_cnt_q;
  assign unused_ok = ^{CHNL_RX_OFF, cmd_head, cmd_count};
  riffa_reg_if_batch_fifo #(.W(W), .D(CMD_FIFO_DEPTH)) u_cmd (
    .clk(clk), .rst_n(rst_n), .push(rx_accept), .din(CHNL_RX_DATA), .pop(exec_pop),
    .dout(cmd_head), .empty(cmd_empty), .full(cmd_full), .count(cmd_count)
  );
  riffa_reg_if_batch_fifo #(.W(W), .D(RSP_FIFO_DEPTH)) u_rsp (
    .clk(clk), .rst_n(rst_n), .push(rsp_push), .din(rsp_din), .pop(tx_pop),
    .dout(rsp_head), .empty(rsp_empty), .full(rsp_full), .count(rsp_count)
  );
  always_comb begin
    rx_state_d = rx_state_q;
    rx_len_d = rx_len_q;
    rx_last_d = rx_last_q;
    rx_cnt_d = rx_cnt_q;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        rx_state_d = CHNL_RX ? RX_ACK : RX_IDLE;
      end
      RX_ACK: begin
        rx_len_d = CHNL_RX_LEN;
        rx_last_d = CHNL_RX_LAST;
        rx_state_d = CHNL_RX_LEN == '0 ? RX_DONE : RX_RECV;
      end
      RX_RECV: begin
        rx_cnt_d = rx_accept ? rx_cnt_q + 32'(WPB) : rx_cnt_q;
        rx_state_d = (!CHNL_RX || rx_cnt_d >= rx_len_q) ? RX_DONE : RX_RECV;
      end
      default: rx_state_d = CHNL_RX ? RX_DONE : RX_IDLE;
    endcase
  end
  // flush is requested once, on entry to DONE, so a lingering CHNL_RX cannot re-arm it
  assign flush_set = rx_state_q != RX_DONE && rx_state_d == RX_DONE && rx_last_d;
  assign op = cmd_head[63:48];
  assign ea = cmd_head[47:32];
  assign ed = cmd_head[31:0];
  assign is_wr = op == 16'hFFFF;
  assign is_rd = op == 16'h0000;
  assign in_reg = {16'd0, ea} < 32'(REG_COUNT);
  assign in_any = {16'd0, ea} < 32'(REG_COUNT + STAT_COUNT);
  assign exec_pop = !cmd_empty && tx_state_q == TX_IDLE && (!is_rd || !rsp_full);
  assign rsp_push = exec_pop && is_rd;
  assign rsp_din = W'({16'h0000, ea, rd_val});
  assign bad = exec_pop && (is_wr ? !in_reg : is_rd ? !in_any : 1'b1);
  assign err_cnt_d = (bad && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
  always_comb begin
    rd_val = 32'hDEADBEEF;
    for (int i = 0; i < REG_COUNT; i++) if (ea == 16'(i)) rd_val = 32'(bank_q[i]);
    for (int i = 0; i < STAT_COUNT; i++) if (ea == 16'(REG_COUNT + i)) rd_val = status_in[i*32 +: 32];
  end
  always_comb begin
    for (int i = 0; i < REG_COUNT; i++)
      bank_d[i] = (exec_pop && is_wr && ea == 16'(i)) ? ed[REG_DATA_WIDTH-1:0] : bank_q[i];
  end
  always_comb begin
    tx_state_d = tx_state_q;
    tx_len_d = tx_len_q;
    tx_beats_d = tx_beats_q;
    tx_cnt_d = tx_cnt_q;
    flush_clr = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (flush_pending_q && cmd_empty) begin
          flush_clr = rsp_count == '0;
          tx_state_d = rsp_count == '0 ? TX_IDLE : TX_REQ;
          tx_len_d = rsp_count == '0 ? tx_len_q : 32'(rsp_count) * 32'(WPB);
          tx_beats_d = rsp_count;
        end
      end
      TX_REQ: begin
        tx_cnt_d = '0;
        tx_state_d = CHNL_TX_ACK ? TX_SEND : TX_REQ;
      end
      default: begin
        tx_cnt_d = tx_pop ? tx_cnt_q + RCW'(1) : tx_cnt_q;
        flush_clr = tx_pop && tx_cnt_d == tx_beats_q;
        tx_state_d = flush_clr ? TX_IDLE : TX_SEND;
      end
    endcase
  end
  assign flush_pending_d = flush_set || (flush_pending_q && !flush_clr);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      tx_state_q <= TX_IDLE;
      rx_len_q <= '0;
      rx_cnt_q <= '0;
      rx_last_q <= 1'b0;
      tx_len_q <= '0;
      tx_beats_q <= '0;
      tx_cnt_q <= '0;
      flush_pending_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      tx_state_q <= tx_state_d;
      rx_len_q <= rx_len_d;
      rx_cnt_q <= rx_cnt_d;
      rx_last_q <= rx_last_d;
      tx_len_q <= tx_len_d;
      tx_beats_q <= tx_beats_d;
      tx_cnt_q <= tx_cnt_d;
      flush_pending_q <= flush_pending_d;
      err_cnt_q <= err_cnt_d;
    end
  end
`ifdef RIFFA_REG_RESET_EN
  always_ff @(posedge clk) begin
    if (!rst_n) bank_q <= '{default: '0};
    else bank_q <= bank_d;
  end
`else
  always_ff @(posedge clk) bank_q <= bank_d;
`endif
  for (genvar g = 0; g < REG_COUNT; g++) begin : g_reg
    assign reg_q[g*REG_DATA_WIDTH +: REG_DATA_WIDTH] = bank_q[g];
  end
endmodule

// File: tb/tb_riffa_reg_if_batch.sv
// tb_riffa_reg_if_batch: randomized self-checking bench for riffa_reg_if_batch against a command-level model
module tb_riffa_reg_if_batch;
  localparam int W = 64;
  localparam int RC = 16;
  localparam int RDW = 16;
  localparam int SC = 4;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  logic rx_clk, tx_clk, rx = 0, rx_ack, rx_last = 0, rx_valid = 0, rx_ren;
  logic [31:0] rx_len = 0;
  logic [30:0] rx_off = 0;
  logic [W-1:0] rx_data = 0;
  logic tx, tx_ack = 0, tx_last, tx_valid, tx_ren = 0;
  logic [31:0] tx_len;
  logic [30:0] tx_off;
  logic [W-1:0] tx_data;
  logic [RC*RDW-1:0] reg_q;
  logic [SC*32-1:0] status_in;
  logic [15:0] err_cnt;
  int checks = 0, errors = 0;
  logic [15:0] mreg [RC];
  bit mval [RC];
  int merr = 0, pend = 0, cur_n = 0;
  logic [63:0] exp_rsp [$];
  int exp_len [$];
  logic [63:0] beats [$];

  riffa_reg_if_batch #(.C_PCI_DATA_WIDTH(W), .REG_COUNT(RC), .REG_DATA_WIDTH(RDW), .STAT_COUNT(SC),
                       .CMD_FIFO_DEPTH(4), .RSP_FIFO_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .CHNL_RX_CLK(rx_clk), .CHNL_RX(rx), .CHNL_RX_ACK(rx_ack), .CHNL_RX_LAST(rx_last),
    .CHNL_RX_LEN(rx_len), .CHNL_RX_OFF(rx_off), .CHNL_RX_DATA(rx_data),
    .CHNL_RX_DATA_VALID(rx_valid), .CHNL_RX_DATA_REN(rx_ren),
    .CHNL_TX_CLK(tx_clk), .CHNL_TX(tx), .CHNL_TX_ACK(tx_ack), .CHNL_TX_LAST(tx_last),
    .CHNL_TX_LEN(tx_len), .CHNL_TX_OFF(tx_off), .CHNL_TX_DATA(tx_data),
    .CHNL_TX_DATA_VALID(tx_valid), .CHNL_TX_DATA_REN(tx_ren),
    .reg_q(reg_q), .status_in(status_in), .err_cnt(err_cnt)
  );

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] wr(input logic [15:0] a, input logic [31:0] d);
    return {16'hFFFF, a, d};
  endfunction

  function automatic logic [63:0] rd(input logic [15:0] a);
    return {16'h0000, a, 32'h0};
  endfunction

  task automatic model(input logic [63:0] b);
    logic [15:0] op, a;
    logic [31:0] v;
    op = b[63:48];
    a = b[47:32];
    if (op == 16'hFFFF) begin
      if (a < RC) begin
        mreg[a] = b[15:0];
        mval[a] = 1;
      end else merr++;
    end else if (op == 16'h0000) begin
      if (a < RC) v = {16'h0, mreg[a]};
      else if (a < RC + SC) v = status_in[(int'(a) - RC)*32 +: 32];
      else begin
        v = 32'hDEADBEEF;
        merr++;
      end
      exp_rsp.push_back({16'h0000, a, v});
      pend++;
    end else merr++;
    if (merr > 16'hFFFF) merr = 16'hFFFF;
  endtask

  task automatic model_reset;
    merr = 0;
    pend = 0;
    exp_rsp.delete();
    exp_len.delete();
    for (int i = 0; i < RC; i++) begin
`ifdef RIFFA_REG_RESET_EN
      mreg[i] = '0;
      mval[i] = 1;
`else
      mval[i] = 0;
`endif
    end
  endtask

  task automatic send_txn(input bit last);
    int t;
    bit acc;
    foreach (beats[i]) model(beats[i]);
    if (last && pend > 0) exp_len.push_back(pend);
    if (last) pend = 0;
    rx = 1;
    rx_len = 32'(beats.size() * 2);
    rx_last = last;
    t = 0;
    tick;
    while (!rx_ack && t < 100) begin
      tick;
      t++;
    end
    checks++;
    if (rx_ack !== 1'b1) begin
      errors++;
      $display("FAIL rx_ack_seen: got %b want 1", rx_ack);
    end
    tick;
    checks++;
    if (rx_ack !== 1'b0) begin
      errors++;
      $display("FAIL rx_ack_one_cycle: got %b want 0", rx_ack);
    end
    foreach (beats[i]) begin
      rx_data = beats[i];
      rx_valid = 1;
      t = 0;
      acc = 0;
      while (!acc && t < 500) begin
        acc = rx_ren;
        tick;
        t++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL rx_beat_timeout: beat %0d never accepted", i);
      end
    end
    rx_valid = 0;
    rx = 0;
    tick;
    tick;
    beats.delete();
  endtask

  task automatic tx_accept;
    int t;
    t = 0;
    cur_n = exp_len.size() > 0 ? exp_len.pop_front() : 0;
    while (!tx && t < 300) begin
      tick;
      t++;
    end
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL tx_req: got %b want 1", tx);
    end
    checks++;
    if (tx_len !== 32'(cur_n * 2)) begin
      errors++;
      $display("FAIL tx_len: got %0d want %0d", tx_len, cur_n * 2);
    end
    tx_ack = 1;
    tick;
    tx_ack = 0;
  endtask

  task automatic tx_drain;
    int t, got;
    logic [63:0] e;
    tx_ren = 1;
    t = 0;
    got = 0;
    while (got < cur_n && t < 500) begin
      if (tx_valid) begin
        e = exp_rsp.size() > 0 ? exp_rsp.pop_front() : 64'hx;
        checks++;
        if (tx_data !== e) begin
          errors++;
          $display("FAIL tx_data[%0d]: got %h want %h", got, tx_data, e);
        end
        got++;
      end
      tick;
      t++;
    end
    tx_ren = 0;
    if (got < cur_n) begin
      checks++;
      errors++;
      $display("FAIL tx_drain_timeout: got %0d beats want %0d", got, cur_n);
    end
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL tx_drop: got %b want 0", tx);
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) tick;
    rst_n = 1;
    model_reset();
    checks += 8;
    if (rx_ack !== 0) begin errors++; $display("FAIL reset_rx_ack: got %b want 0", rx_ack); end
    if (rx_ren !== 0) begin errors++; $display("FAIL reset_rx_ren: got %b want 0", rx_ren); end
    if (tx !== 0) begin errors++; $display("FAIL reset_tx: got %b want 0", tx); end
    if (tx_valid !== 0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    if (tx_last !== 1) begin errors++; $display("FAIL reset_tx_last: got %b want 1", tx_last); end
    if (tx_off !== 0) begin errors++; $display("FAIL reset_tx_off: got %h want 0", tx_off); end
    if (tx_len !== 0) begin errors++; $display("FAIL reset_tx_len: got %h want 0", tx_len); end
    if (err_cnt !== 0) begin errors++; $display("FAIL reset_err_cnt: got %h want 0", err_cnt); end
  endtask

  task automatic test_writes_only;
    bit seen;
    for (int i = 0; i < RC; i++) beats.push_back(wr(16'(i), $urandom));
    send_txn(1);
    seen = 0;
    repeat (20) begin
      seen |= tx;
      tick;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL wo_no_tx: got 1 want 0"); end
    checks++;
    if (dut.flush_pending_q !== 1'b0) begin errors++; $display("FAIL wo_flush_clear: got %b want 0", dut.flush_pending_q); end
    for (int i = 0; i < RC; i++) begin
      checks++;
      if (reg_q[i*RDW +: RDW] !== mreg[i]) begin
        errors++;
        $display("FAIL wo_reg[%0d]: got %h want %h", i, reg_q[i*RDW +: RDW], mreg[i]);
      end
    end
  endtask

  task automatic test_basic;
    beats.push_back(wr(16'd3, 32'h1234));
    beats.push_back(rd(16'd3));
    send_txn(1);
    checks++;
    if (reg_q[3*RDW +: RDW] !== 16'h1234) begin errors++; $display("FAIL basic_reg3: got %h want 1234", reg_q[3*RDW +: RDW]); end
    checks++;
    if (exp_rsp.size() != 1 || exp_rsp[0][47:0] !== 48'h0003_0000_1234) begin errors++; $display("FAIL basic_model: model response wrong"); end
    tx_accept();
    tx_drain();
  endtask

  task automatic test_status;
    beats.push_back(rd(16'd0));
    beats.push_back(rd(16'(RC)));
    beats.push_back(rd(16'h00FF));
    send_txn(1);
    tx_accept();
    tx_drain();
    checks++;
    if (err_cnt !== 16'(merr)) begin errors++; $display("FAIL status_err_cnt: got %0d want %0d", err_cnt, merr); end
  endtask

  task automatic test_multi_txn;
    bit seen;
    beats.push_back(rd(16'($urandom_range(0, RC + SC - 1))));
    beats.push_back(rd(16'($urandom_range(0, RC + SC - 1))));
    send_txn(0);
    seen = 0;
    repeat (15) begin
      seen |= tx;
      tick;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL multi_early_tx: got 1 want 0"); end
    beats.push_back(rd(16'($urandom_range(0, RC - 1))));
    send_txn(1);
    checks++;
    if (exp_len.size() != 1 || exp_len[0] != 3) begin errors++; $display("FAIL multi_model: model batch size wrong"); end
    tx_accept();
    tx_drain();
  endtask

  task automatic test_random;
    bit seen;
    repeat (6) begin
      int nt;
      nt = $urandom_range(1, 3);
      for (int k = 0; k < nt; k++) begin
        int nc;
        nc = $urandom_range(1, 4);
        for (int c = 0; c < nc; c++) begin
          case ($urandom_range(0, 5))
            0, 1: beats.push_back(wr(16'($urandom_range(0, RC + SC + 1)), $urandom));
            2, 3: beats.push_back(rd(16'($urandom_range(0, RC + SC + 1))));
            4: beats.push_back(rd(16'h00FF));
            default: beats.push_back({16'(1 + $urandom_range(0, 16'hFFFC)), 16'($urandom), 32'($urandom)});
          endcase
        end
        send_txn(k == nt - 1);
      end
      if (exp_len.size() > 0) begin
        tx_accept();
        tx_drain();
      end else begin
        seen = 0;
        repeat (15) begin
          seen |= tx;
          tick;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL rand_no_tx: got 1 want 0"); end
      end
      checks++;
      if (err_cnt !== 16'(merr)) begin errors++; $display("FAIL rand_err_cnt: got %0d want %0d", err_cnt, merr); end
    end
    for (int i = 0; i < RC; i++) begin
      checks++;
      if (mval[i] && reg_q[i*RDW +: RDW] !== mreg[i]) begin
        errors++;
        $display("FAIL rand_reg[%0d]: got %h want %h", i, reg_q[i*RDW +: RDW], mreg[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    beats.push_back(rd(16'd1));
    beats.push_back(rd(16'd2));
    send_txn(1);
    tx_accept();
    for (int i = 0; i < 4; i++) begin
      beats.push_back(wr(16'(4 + i), $urandom));
      beats.push_back(rd(16'(4 + i)));
    end
    fork
      send_txn(1);
      begin
        repeat (20) tick;
        checks++;
        if (rx_ren !== 1'b0) begin errors++; $display("FAIL bp_ren_full: got %b want 0", rx_ren); end
        tx_drain();
      end
    join
    tx_accept();
    tx_drain();
    for (int i = 4; i < 8; i++) begin
      checks++;
      if (reg_q[i*RDW +: RDW] !== mreg[i]) begin
        errors++;
        $display("FAIL bp_reg[%0d]: got %h want %h", i, reg_q[i*RDW +: RDW], mreg[i]);
      end
    end
  endtask

  task automatic test_mid_reset;
    int t;
    rx = 1;
    rx_len = 8;
    rx_last = 1;
    t = 0;
    tick;
    while (!rx_ack && t < 100) begin
      tick;
      t++;
    end
    tick;
    rx_data = wr(16'd5, 32'h5A5A);
    rx_valid = 1;
    tick;
    rx_valid = 0;
    beats.push_back(16'h1234 << 48);
    rx_data = beats[0];
    beats.delete();
    rx_valid = 1;
    tick;
    rx_valid = 0;
    rx = 0;
    rst_n = 0;
    tick;
    rst_n = 1;
    model_reset();
    checks += 5;
    if (rx_ren !== 0) begin errors++; $display("FAIL mid_rx_ren: got %b want 0", rx_ren); end
    if (rx_ack !== 0) begin errors++; $display("FAIL mid_rx_ack: got %b want 0", rx_ack); end
    if (tx !== 0) begin errors++; $display("FAIL mid_tx: got %b want 0", tx); end
    if (err_cnt !== 0) begin errors++; $display("FAIL mid_err_cnt: got %h want 0", err_cnt); end
    if (dut.cmd_empty !== 1'b1) begin errors++; $display("FAIL mid_cmd_empty: got %b want 1", dut.cmd_empty); end
`ifdef RIFFA_REG_RESET_EN
    for (int i = 0; i < RC; i++) begin
      checks++;
      if (reg_q[i*RDW +: RDW] !== '0) begin errors++; $display("FAIL mid_reg[%0d]: got %h want 0", i, reg_q[i*RDW +: RDW]); end
    end
`endif
    beats.push_back(wr(16'd5, $urandom));
    beats.push_back(rd(16'd5));
    send_txn(1);
    tx_accept();
    tx_drain();
  endtask

  initial begin
    status_in = {32'($urandom), 32'($urandom), 32'($urandom), 32'hCAFEF00D};
    test_reset();
    test_writes_only();
    test_basic();
    test_status();
    test_multi_txn();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/riffa_reg_if_batch.md
Name: riffa_reg_if_batch

Overview:
- Parametrised single-channel RIFFA command engine.
- Accepts multi-word RX transactions of register commands into a command FIFO and executes them one per cycle against a parametrised register bank plus a read-only status window.
- Batches all read responses of a host transaction into one TX transaction.
- Sits between the RIFFA channel ports and user logic; exposes the register bank as flat outputs.

Parameters:
- C_PCI_DATA_WIDTH, 64, channel data width; legal values 64 or 128.
- REG_COUNT, 16, number of read/write registers (1..256).
- REG_DATA_WIDTH, 16, register width (1..32).
- STAT_COUNT, 4, number of read-only 32-bit status words.
- CMD_FIFO_DEPTH, 16, command FIFO depth in beats; power of 2.
- RSP_FIFO_DEPTH, 16, response FIFO depth in beats; power of 2.

Ports:
- clk  in  1  single clock for all logic and both channel directions.
- rst_n  in  1  synchronous active-low reset.
- CHNL_RX_CLK / CHNL_TX_CLK  out  1 each  driven by clk.
- CHNL_RX, CHNL_RX_LAST, CHNL_RX_DATA_VALID  in  1 each  RIFFA RX controls.
- CHNL_RX_LEN  in  32  transaction length in 32-bit words.
- CHNL_RX_OFF  in  31  ignored.
- CHNL_RX_DATA  in  C_PCI_DATA_WIDTH  command beat.
- CHNL_RX_ACK, CHNL_RX_DATA_REN  out  1 each.
- CHNL_TX, CHNL_TX_LAST, CHNL_TX_DATA_VALID  out  1 each.
- CHNL_TX_LEN  out  32;  CHNL_TX_OFF  out  31;  CHNL_TX_DATA  out  C_PCI_DATA_WIDTH.
- CHNL_TX_ACK, CHNL_TX_DATA_REN  in  1 each.
- reg_q  out  REG_COUNT*REG_DATA_WIDTH  register bank; reg i at [i*REG_DATA_WIDTH +: REG_DATA_WIDTH].
- status_in  in  STAT_COUNT*32  read-only status words.
- err_cnt  out  16  saturating count of bad commands.

Behaviour:
- Reset: all FSMs to IDLE; FIFOs empty; counters, err_cnt and all channel outputs 0. Exceptions: CHNL_TX_LAST is constant 1 and CHNL_TX_OFF is constant 0. A mid-transaction reset abandons the transaction.
- Command beat fields (bits above 63 ignored): opcode [63:48], addr [47:32], data [31:0].
  - opcode 16'hFFFF = write; 16'h0000 = read; any other = error.
- RX FSM:
  - IDLE -> ACK when CHNL_RX=1. In ACK, CHNL_RX_ACK=1 for exactly one cycle; latch CHNL_RX_LAST and CHNL_RX_LEN.
  - ACK -> RECV, or -> DONE if the latched LEN is 0.
  - RECV: CHNL_RX_DATA_REN = ~cmd_full. A beat is accepted when REN&VALID; it is pushed to the command FIFO and rx_cnt += C_PCI_DATA_WIDTH/32.
  - RECV -> DONE when rx_cnt >= latched LEN, or when CHNL_RX falls (abort).
  - DONE: if the latched LAST is 1, set flush_pending. DONE -> IDLE when CHNL_RX=0. rx_cnt clears in IDLE.
- Exec: pops one command per cycle when the command FIFO is non-empty, TX FSM is IDLE, and (not a read or the response FIFO is not full). Otherwise it stalls with no loss.
  - Write, addr<REG_COUNT: reg[addr] <= data[REG_DATA_WIDTH-1:0], visible on reg_q the next cycle.
  - Read: pushes a response beat {zeros, 16'h0000, addr, value zero-extended to 32}.
    - addr<REG_COUNT: value = register.
    - REG_COUNT<=addr<REG_COUNT+STAT_COUNT: value = status word (addr-REG_COUNT).
    - Otherwise: value 32'hDEADBEEF and err_cnt++.
  - Write to a status or out-of-range address, or an unknown opcode: no state change, err_cnt++ (saturates at 16'hFFFF).
- Flush: when flush_pending=1, the command FIFO is empty and exec is idle:
  - rsp_count=0: clear flush_pending.
  - Otherwise: TX FSM IDLE -> REQ.
- TX FSM:
  - REQ: CHNL_TX=1, CHNL_TX_LEN = rsp_count*(C_PCI_DATA_WIDTH/32), latched.
  - REQ -> SEND on CHNL_TX_ACK.
  - SEND: CHNL_TX=1, CHNL_TX_DATA_VALID = rsp non-empty, data = FIFO head; pop on VALID&REN.
  - After the latched count of beats -> IDLE; CHNL_TX drops and flush_pending clears.
- Simultaneous events: RX may fill the command FIFO while TX is busy; exec resumes after TX returns to IDLE. A read pushed while the response FIFO is full is impossible because exec stalls first.
- FIFO latency: first-word-fall-through. A pushed beat is poppable the next cycle.

Optional Feature:
- RIFFA_REG_RESET_EN
  - Defined: rst_n clears every bank register to 0.
  - Undefined: bank registers have no reset; their value until first write is undefined (reg_q is X in simulation). All other reset behaviour is unchanged.

Test Plan:
- LEN=4, LAST=1, two beats: write addr 3 = 0x1234; read addr 3. Required: RX_ACK one cycle; reg_q slice 3 = 0x1234; one TX transaction, TX_LEN=2, data[47:0]=0x0003_0000_1234.
- Three reads (addr 0, REG_COUNT, 0x00FF), status_in word0=0xCAFEF00D. Required: TX_LEN=6; values reg0, 0xCAFEF00D, 0xDEADBEEF; err_cnt=1.
- Transaction with LAST=0 containing two reads, then a LAST=1 transaction with one read. Required: single TX transaction with LEN=6 after the second transaction, responses in order.
- CMD_FIFO_DEPTH=4, CHNL_TX_DATA_REN held 0 during a prior flush, 8-beat RX. Required: RX_DATA_REN drops at full; all 8 commands executed after release, none lost.
- Writes only, LAST=1. Required: no CHNL_TX assertion; flush_pending clears.
- rst_n low for one cycle mid-RECV. Required: next cycle all FSMs IDLE, REN=0, FIFOs empty, err_cnt=0; bank cleared only with RIFFA_REG_RESET_EN.
